// File: rtl/tail_light_driver.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_driver
// Purpose  : Decodes the turn-signal mode code into animated 3-lamp tail-light
//            patterns (idle, hazard, left, right). Optional brake overlay is
//            enabled by defining TAIL_LIGHT_BRAKE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tail_light_driver #(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] CurrentState,
`ifdef TAIL_LIGHT_BRAKE_EN
    input  logic       Brake,
`endif
    output logic [2:0] LeftLights,
    output logic [2:0] RightLights,
    output logic       StepTick,
    output logic       Invalid
);

    localparam logic [2:0]       MODE_IDLE   = 3'b000;
    localparam logic [2:0]       MODE_HAZARD = 3'b001;
    localparam logic [2:0]       MODE_LEFT   = 3'b010;
    localparam logic [2:0]       MODE_RIGHT  = 3'b011;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       mode_q;
    logic [1:0]       step_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             animating;
    logic [1:0]       step_next;
    logic [2:0]       seq_pattern;
`ifdef TAIL_LIGHT_BRAKE_EN
    logic             brake_q;
`endif

    assign animating = (mode_q == MODE_HAZARD) || (mode_q == MODE_LEFT) ||
                       (mode_q == MODE_RIGHT);

    // Hazard has only two steps, so its wrap must be forced explicitly.
    assign step_next = (mode_q == MODE_HAZARD) ? ((step_q == 2'd1) ? 2'd0 : 2'd1)
                                               : step_q + 2'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= MODE_IDLE;
            step_q <= 2'd0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
`ifdef TAIL_LIGHT_BRAKE_EN
            brake_q <= 1'b0;
`endif
        end else begin
            mode_q <= CurrentState;
`ifdef TAIL_LIGHT_BRAKE_EN
            brake_q <= Brake;
`endif
            // A mode change takes priority over a coincident terminal count.
            if ((CurrentState != mode_q) || !animating) begin
                step_q <= 2'd0;
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                step_q <= step_next;
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + CNT_ONE;
                tick_q <= 1'b0;
            end
        end
    end

    always_comb begin
        seq_pattern = 3'b000;
        case (step_q)
            2'd0:    seq_pattern = 3'b000;
            2'd1:    seq_pattern = 3'b001;
            2'd2:    seq_pattern = 3'b011;
            default: seq_pattern = 3'b111;
        endcase
    end

    always_comb begin
        LeftLights  = 3'b000;
        RightLights = 3'b000;
        case (mode_q)
            MODE_HAZARD: begin
                LeftLights  = (step_q == 2'd0) ? 3'b111 : 3'b000;
                RightLights = (step_q == 2'd0) ? 3'b111 : 3'b000;
            end
            MODE_LEFT: begin
                LeftLights = seq_pattern;
`ifdef TAIL_LIGHT_BRAKE_EN
                RightLights = brake_q ? 3'b111 : 3'b000;
`endif
            end
            MODE_RIGHT: begin
                RightLights = seq_pattern;
`ifdef TAIL_LIGHT_BRAKE_EN
                LeftLights = brake_q ? 3'b111 : 3'b000;
`endif
            end
            MODE_IDLE: begin
`ifdef TAIL_LIGHT_BRAKE_EN
                LeftLights  = brake_q ? 3'b111 : 3'b000;
                RightLights = brake_q ? 3'b111 : 3'b000;
`endif
            end
            default: begin
                LeftLights  = 3'b000;
                RightLights = 3'b000;
            end
        endcase
    end

    assign StepTick = tick_q;
    assign Invalid  = mode_q[2];

endmodule
`default_nettype wire

// File: tb/tb_tail_light_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tail_light_driver
// Purpose  : Directed scoreboard bench for tail_light_driver with TICK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tail_light_driver;

    logic       clk;
    logic       rst;
    logic [2:0] cs;
    logic       brake;
    logic [2:0] left_l;
    logic [2:0] right_l;
    logic       tick;
    logic       inv;

    int checks;
    int errors;

    logic [7:0] exp_q [$];
    logic [2:0] pat [4];

    tail_light_driver #(
        .TICK_DIV(4),
        .CNT_W   (3)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .CurrentState(cs),
`ifdef TAIL_LIGHT_BRAKE_EN
        .Brake       (brake),
`endif
        .LeftLights  (left_l),
        .RightLights (right_l),
        .StepTick    (tick),
        .Invalid     (inv)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag);
        logic [7:0] obs;
        logic [7:0] expv;
        obs  = {left_l, right_l, tick, inv};
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed L/R/tick/inv=%b expected %b", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus and check the outputs after the next edge.
    task automatic cyc(input logic [2:0] code, input logic [2:0] el, input logic [2:0] er,
                       input logic et, input logic ei, input string tag);
        cs = code;
        exp_q.push_back({el, er, et, ei});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        cs     = 3'b000;
        brake  = 1'b0;
        checks = 0;
        errors = 0;
        pat[0] = 3'b000;
        pat[1] = 3'b001;
        pat[2] = 3'b011;
        pat[3] = 3'b111;

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(8'b0);
        compare("reset_state");
        rst = 1'b0;

        for (int k = 0; k < 20; k++) cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "idle");

        // Left sequence
        cyc(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, "left_enter");
        for (int k = 1; k <= 20; k++)
            cyc(3'b010, pat[(k / 4) % 4], 3'b000, (k % 4) == 0, 1'b0, "left_seq");

        // Hazard
        cyc(3'b001, 3'b111, 3'b111, 1'b0, 1'b0, "hazard_enter");
        for (int k = 1; k <= 12; k++)
            cyc(3'b001, ((k / 4) % 2 == 0) ? 3'b111 : 3'b000,
                ((k / 4) % 2 == 0) ? 3'b111 : 3'b000, (k % 4) == 0, 1'b0, "hazard_seq");

        // Right to step 2, cnt 3, then switch on the terminal-count edge
        cyc(3'b011, 3'b000, 3'b000, 1'b0, 1'b0, "right_enter");
        for (int k = 1; k <= 11; k++)
            cyc(3'b011, 3'b000, pat[(k / 4) % 4], (k % 4) == 0, 1'b0, "right_seq");
        cyc(3'b001, 3'b111, 3'b111, 1'b0, 1'b0, "switch_at_tc");
        for (int k = 1; k <= 3; k++)
            cyc(3'b001, 3'b111, 3'b111, 1'b0, 1'b0, "hazard_after_switch");

        // Invalid code, then recovery into right mode
        for (int k = 0; k < 6; k++)
            cyc(3'b101, 3'b000, 3'b000, 1'b0, 1'b1, "invalid");
        cyc(3'b011, 3'b000, 3'b000, 1'b0, 1'b0, "invalid_exit");
        for (int k = 1; k <= 4; k++)
            cyc(3'b011, 3'b000, (k == 4) ? 3'b001 : 3'b000, k == 4, 1'b0, "right_after_invalid");

        // Asynchronous reset mid-cycle while StepTick and a lamp are lit
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(8'b0);
        compare("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(3'b011, 3'b000, 3'b000, 1'b0, 1'b0, "post_reset_enter");
        for (int k = 1; k <= 4; k++)
            cyc(3'b011, 3'b000, (k == 4) ? 3'b001 : 3'b000, k == 4, 1'b0, "post_reset_right");
        cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "back_to_idle");

`ifdef TAIL_LIGHT_BRAKE_EN
        brake = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc(3'b000, 3'b111, 3'b111, 1'b0, 1'b0, "brake_idle");
        cyc(3'b010, 3'b000, 3'b111, 1'b0, 1'b0, "brake_left_enter");
        for (int k = 1; k <= 8; k++)
            cyc(3'b010, pat[(k / 4) % 4], 3'b111, (k % 4) == 0, 1'b0, "brake_left");
        cyc(3'b001, 3'b111, 3'b111, 1'b0, 1'b0, "brake_hazard_enter");
        for (int k = 1; k <= 8; k++)
            cyc(3'b001, ((k / 4) % 2 == 0) ? 3'b111 : 3'b000,
                ((k / 4) % 2 == 0) ? 3'b111 : 3'b000, (k % 4) == 0, 1'b0, "brake_hazard");
        brake = 1'b0;
        cyc(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, "brake_release");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
